// File: rtl/sng_bank.sv
// sng_bank: N-channel stochastic number generator bank, one maximal-length LFSR plus comparator per channel,
// emitting exactly one full LFSR period of unipolar bitstream per accepted request.
module sng_bank #(
  parameter int N    = 3,
  parameter int W    = 8,
  parameter int SEED = 0
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           START,
  input  logic [N*W-1:0] X,
  input  logic           HOLD,
  output logic           READY,
  output logic [N-1:0]   S,
  output logic           S_VALID,
  output logic           DONE,
  output logic           BUSY
);
  localparam int L = (1 << W) - 1;
  // Tap masks use bit index = tap number - 1.
  localparam logic [7:0] TAPS = W == 4 ? 8'h0C : W == 5 ? 8'h14 : W == 6 ? 8'h30 : W == 7 ? 8'h60 : 8'hB8;
  function automatic logic [N-1:0][W-1:0] seed_init();
    for (int n = 0; n < N; n++) seed_init[n] = W'(1 + ((SEED + 5 * n) % L));
  endfunction
  localparam logic [N-1:0][W-1:0] SEEDS = seed_init();
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [N-1:0][W-1:0] lfsr_q, lfsr_d, xreg_q, xreg_d;
  logic last;
  assign last = cnt_q == W'(L - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    xreg_d  = xreg_q;
    if (state_q == IDLE) begin
      if (START) begin
        state_d = RUN;
        xreg_d  = X;
        lfsr_d  = SEEDS;
        cnt_d   = '0;
      end
    end else if (!HOLD) begin
      for (int n = 0; n < N; n++) lfsr_d[n] = {lfsr_q[n][W-2:0], ^(lfsr_q[n] & TAPS[W-1:0])};
      cnt_d   = cnt_q + 1'b1;
      state_d = last ? IDLE : RUN;
    end
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lfsr_q  <= SEEDS;
      xreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      xreg_q  <= xreg_d;
    end
  end
  assign BUSY    = state_q == RUN;
  assign READY   = ~BUSY;
  assign S_VALID = BUSY & ~HOLD;
  assign DONE    = S_VALID & last;
  always_comb begin
    S = '0;
    for (int n = 0; n < N; n++) S[n] = BUSY & (lfsr_q[n] <= xreg_q[n]);
  end
endmodule

// File: tb/tb_sng_bank.sv
// tb_sng_bank: directed checks of sng_bank (N=3, W=4, SEED=0) against hand-derived stream expectations.
module tb_sng_bank;
  localparam int N = 3, W = 4;
  logic CLK = 0, RST_N = 0, START = 0, HOLD = 0;
  logic [N*W-1:0] X = '0;
  logic READY, S_VALID, DONE, BUSY;
  logic [N-1:0] S;
  int n_vec = 0, n_bad = 0;
  int nv, nd, dpos, pcand;
  int pc[N];
  logic [14:0] sq[N];
  sng_bank #(.N(N), .W(W), .SEED(0)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .X(X), .HOLD(HOLD),
    .READY(READY), .S(S), .S_VALID(S_VALID), .DONE(DONE), .BUSY(BUSY)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Taps 4,3 -> bits 3,2; channel n seed = 1 + (5n mod 15).
  function automatic logic [14:0] exp_seq(input int n, input logic [3:0] x);
    logic [3:0] v;
    v = 4'(1 + (5 * n) % 15);
    for (int i = 0; i < 15; i++) begin
      exp_seq[i] = v <= x;
      v = {v[2:0], v[3] ^ v[2]};
    end
  endfunction
  task automatic run(input logic [11:0] x, input int hold_pct, input int poke_at, input int abort_at);
    bit fin;
    nv = 0; nd = 0; dpos = 0; pcand = 0; fin = 0;
    for (int n = 0; n < N; n++) begin pc[n] = 0; sq[n] = '0; end
    @(negedge CLK); X = x; START = 1; HOLD = 0;
    @(negedge CLK); START = 0;
    for (int t = 0; t < 200 && !fin; t++) begin
      HOLD = hold_pct > 0 && ($urandom_range(99) < hold_pct);
      #1;
      if (!BUSY) begin
        fin = 1;
        chk("ready_after", READY, 1);
      end else begin
        if (HOLD) chk("hold_svalid", S_VALID, 0);
        if (S_VALID) begin
          for (int n = 0; n < N; n++) begin pc[n] += S[n]; if (nv < 15) sq[n][nv] = S[n]; end
          pcand += &S;
          nv++;
          if (DONE) begin nd++; dpos = nv; end
        end
        START = poke_at > 0 && nv == poke_at && S_VALID;
        if (START) X = ~x;
        if (abort_at > 0 && nv == abort_at) begin
          #2 RST_N = 0;
          #1;
          chk("abort_s", S, 0);
          chk("abort_svalid", S_VALID, 0);
          chk("abort_done", DONE, 0);
          chk("abort_busy", BUSY, 0);
          chk("abort_ready", READY, 1);
          @(negedge CLK); #3 RST_N = 1;
          fin = 1;
        end
        if (!fin) @(negedge CLK);
      end
    end
    if (!fin) chk("timeout", 0, 1);
    HOLD = 0; START = 0;
  endtask
  task automatic stream_chk(input string tag, input logic [11:0] x);
    chk({tag, "_valid"}, nv, 15);
    chk({tag, "_ndone"}, nd, 1);
    chk({tag, "_donepos"}, dpos, 15);
    for (int n = 0; n < N; n++) begin
      chk($sformatf("%s_pop%0d", tag, n), pc[n], x[n*4+:4]);
      chk($sformatf("%s_seq%0d", tag, n), sq[n], exp_seq(n, x[n*4+:4]));
    end
  endtask
  initial begin
    logic [11:0] x1, x6;
    int streams, gap;
    x1 = {4'd0, 4'd15, 4'd5};
    x6 = {4'd3, 4'd8, 4'd12};
    #12;
    chk("rst_ready", READY, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_s", S, 0);
    chk("rst_svalid", S_VALID, 0);
    chk("rst_done", DONE, 0);
    RST_N = 1;
    run(x1, 0, 0, 0);
    stream_chk("s1", x1);
    for (int x0 = 0; x0 < 16; x0++) begin
      run({4'd15, 4'd15, 4'(x0)}, 0, 0, 0);
      chk($sformatf("sweep%0d_pop0", x0), pc[0], x0);
      chk($sformatf("sweep%0d_and", x0), pcand, x0);
      chk($sformatf("sweep%0d_valid", x0), nv, 15);
    end
    run(x1, 30, 0, 0);
    stream_chk("hold", x1);
    run(x1, 0, 7, 0);
    stream_chk("poke", x1);
    run(x1, 0, 0, 6);
    run(x1, 0, 0, 0);
    stream_chk("post_rst", x1);
    @(negedge CLK); X = x6; START = 1;
    streams = 0; gap = 0;
    for (int n = 0; n < N; n++) pc[n] = 0;
    for (int t = 0; t < 120 && streams < 3; t++) begin
      @(negedge CLK); #1;
      if (BUSY) begin
        if (gap > 0) begin chk("b2b_gap", gap, 1); gap = 0; end
        if (S_VALID) for (int n = 0; n < N; n++) pc[n] += S[n];
        if (DONE) begin
          for (int n = 0; n < N; n++) begin
            chk($sformatf("b2b%0d_pop%0d", streams, n), pc[n], x6[n*4+:4]);
            pc[n] = 0;
          end
          streams++;
        end
      end else gap++;
    end
    START = 0;
    chk("b2b_streams", streams, 3);
    @(negedge CLK); @(negedge CLK); #1;
    chk("b2b_idle", READY, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sng_bank.md
Name: sng_bank

Overview:
- Bank of N stochastic number generators. Converts N unsigned W-bit binary operands into N parallel unipolar bitstreams.
- Sits directly upstream of the cascaded multi-input AND stage (stochastic multiplier), which consumes S[N-1:0] bit-parallel, one bit per clock.
- Each channel has its own maximal-length LFSR and a comparator. The bank emits exactly one full LFSR period per accepted request.

Parameters:
- N, 3, number of channels; matches the AND stage input count (N >= 2).
- W, 8, operand/LFSR width; legal 4..8.
- SEED, 0, base seed offset; integer 0..2^W-2.

Ports:
- CLK, in, 1, clock; all state on rising edge.
- RST_N, in, 1, asynchronous active-low reset.
- START, in, 1, request; accepted when START & READY at a rising edge.
- X, in, N*W, operands; channel n = X[n*W+W-1 : n*W]; sampled only on acceptance.
- HOLD, in, 1, stall during RUN.
- READY, out, 1, high in IDLE.
- S, out, N, bitstreams; bit n feeds AND input n.
- S_VALID, out, 1, S is a valid stream bit this cycle.
- DONE, out, 1, high in the cycle carrying the last stream bit.
- BUSY, out, 1, high in RUN.

Behaviour:
- Reset: applies asynchronously on RST_N low. State=IDLE, READY=1, BUSY=0, S=0, S_VALID=0, DONE=0. Xreg=0, counter=0, LFSR_n=seed_n.
- Reset mid-RUN aborts the stream immediately. No DONE is produced.
- Seeds: seed_n = 1 + ((SEED + 5n) mod (2^W-1)). Always nonzero.
- LFSR: Fibonacci, shift left, feedback XOR into bit 0. Feedback is the XOR of the tap bits, numbered 1..W:
  - W=4: taps 4,3
  - W=5: taps 5,3
  - W=6: taps 6,5
  - W=7: taps 7,6
  - W=8: taps 8,6,5,4
- Period L = 2^W-1. LFSR never holds 0.
- Two states, IDLE and RUN. Transitions:
  - IDLE -> RUN: on acceptance edge (START=1 in IDLE). Latch Xreg_n from X, reload LFSR_n=seed_n, counter=0.
  - RUN: each edge with HOLD=0 advances all LFSRs and counter += 1.
  - HOLD=1: freezes LFSRs and counter; S_VALID=0 that cycle.
  - RUN -> IDLE: on the edge after the cycle where counter==L-1 and HOLD=0.
- START while in RUN is ignored. READY=0 throughout RUN. X changes during RUN have no effect.
- Output (combinational from registers, gated by state):
  - S[n] = (state==RUN) & (LFSR_n <= Xreg_n), unsigned compare.
  - S_VALID = (state==RUN) & ~HOLD.
  - DONE = S_VALID & (counter==L-1). One cycle.
  - BUSY = (state==RUN). READY = ~BUSY.
- Latency: first valid bit appears in the cycle immediately after the acceptance edge. With no HOLD, exactly L valid cycles, then READY returns the next cycle.
- Accuracy contract: over one full stream, the count of ones on S[n] equals Xreg_n exactly, for all values 0..2^W-1.
  - X=0 gives an all-zero stream.
  - X=2^W-1 gives an all-one stream.
- Back-to-back: a START held high through the DONE cycle is accepted on the first edge after returning to IDLE (READY=1). This leaves one idle cycle between streams.
- HOLD in IDLE has no effect. HOLD on the DONE cycle delays DONE until the next non-HOLD cycle.

Test Plan:
1. N=3, W=4, SEED=0; X={0,15,5}, START 1 cycle -> exactly 15 S_VALID cycles; popcounts of S = 0, 15, 5; DONE one cycle, coincident with the 15th valid bit; READY=1 the following cycle.
2. Sweep X0 over 0..15 (X1=X2=15), one stream each -> popcount(S[0]) == X0 every run; stream of S[0]&S[1]&S[2] popcount == X0.
3. HOLD random ~30% during RUN -> still exactly 15 valid cycles; popcounts unchanged versus scenario 1; S_VALID=0 and LFSR/counter frozen on HOLD cycles.
4. START pulsed at valid cycle 7 and X changed mid-stream -> ignored; popcounts reflect originally latched X; only one DONE.
5. RST_N asserted low at valid cycle 6, asynchronous to CLK -> S, S_VALID, DONE, BUSY all 0 immediately; READY=1; next stream after reset reproduces the scenario 1 bit sequence exactly (seeds reloaded).
6. START held high continuously, X={3,8,12} -> consecutive streams separated by exactly one idle cycle; each stream's popcounts are 3, 8, 12.
